// File: rtl/i2c_target.sv
// Single-address I2C target. SCL/SDA are oversampled on clk_i. The block
// detects START/STOP, matches ADDR and moves bytes in both directions. SDA is
// open-drain: the block only pulls it low or releases it. There is no clock
// stretching.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus free or unknown, SDA released, waiting for START
// ADDR     | shifting in the address byte (7-bit address + R/W)
// ADDR_ACK | address matched, pulling SDA low for the 9th clock
// WR_DATA  | shifting in a byte written by the master
// WR_ACK   | pulling SDA low for the 9th clock after a written byte
// RD_DATA  | shifting out a byte the master reads
// RD_ACK   | SDA released, sampling the master ACK/NACK on the 9th rise
// IGNORE   | not addressed (or master NACKed), waiting for START/STOP
module i2c_target #(
    parameter logic [6:0] ADDR        = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       scl_i,
    inout  wire        sda_io,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       addressed,
    output logic       rw,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        IDLE, ADDR_S, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_c, stop_c;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       byte_done_q, byte_done_d;
    logic       sda_low_q, sda_low_d;
    logic       addressed_q, addressed_d;
    logic       rw_q, rw_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       start_det_q, start_det_d;
    logic       stop_det_q, stop_det_d;

    // Synchronizer shift chains for the asynchronous bus lines.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_io};
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign start_c  = scl_s & sda_prev_q & ~sda_s;
    assign stop_c   = scl_s & ~sda_prev_q & sda_s;

    // Next-state and datapath logic; bus conditions override every state.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        byte_done_d = byte_done_q;
        sda_low_d   = sda_low_q;
        addressed_d = addressed_q;
        rw_d        = rw_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        start_det_d = start_c & ~stop_c;
        stop_det_d  = stop_c;

        if (stop_c) begin
            state_d     = IDLE;
            addressed_d = 1'b0;
            sda_low_d   = 1'b0;
            byte_done_d = 1'b0;
        end else if (start_c) begin
            state_d     = ADDR_S;
            cnt_d       = 3'd7;
            addressed_d = 1'b0;
            sda_low_d   = 1'b0;
            byte_done_d = 1'b0;
        end else begin
            case (state_q)
                ADDR_S: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) begin
                            if (shift_q[6:0] == ADDR) begin
                                rw_d        = sda_s;
                                byte_done_d = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end else if (scl_fall && byte_done_q) begin
                        state_d     = ADDR_ACK;
                        sda_low_d   = 1'b1;
                        addressed_d = 1'b1;
                        byte_done_d = 1'b0;
                    end
                end
                ADDR_ACK, RD_ACK: begin
                    if (scl_rise) begin
                        if (state_q == ADDR_ACK) begin
                            tx_req_d = rw_q;
                        end else if (!sda_s) begin
                            tx_req_d = 1'b1;
                        end else begin
                            addressed_d = 1'b0;
                            state_d     = IGNORE;
                        end
                    end else if (scl_fall) begin
                        // Any fall seen here follows an ACK (a NACK already left).
                        cnt_d = 3'd7;
                        if (state_q == RD_ACK || rw_q) begin
                            shift_d   = tx_data;
                            sda_low_d = ~tx_data[7];
                            state_d   = RD_DATA;
                        end else begin
                            sda_low_d = 1'b0;
                            state_d   = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) begin
                            rx_data_d   = {shift_q[6:0], sda_s};
                            rx_valid_d  = 1'b1;
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        state_d     = WR_ACK;
                        sda_low_d   = 1'b1;
                        byte_done_d = 1'b0;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_low_d = 1'b0;
                        cnt_d     = 3'd7;
                        state_d   = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        cnt_d = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) begin
                            sda_low_d = 1'b0;
                            state_d   = RD_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_low_d = ~shift_q[6];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers; synchronizers reset to the idle bus level.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= IDLE;
            shift_q     <= 8'h00;
            cnt_q       <= 3'd0;
            byte_done_q <= 1'b0;
            sda_low_q   <= 1'b0;
            addressed_q <= 1'b0;
            rw_q        <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_s;
            sda_prev_q  <= sda_s;
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            byte_done_q <= byte_done_d;
            sda_low_q   <= sda_low_d;
            addressed_q <= addressed_d;
            rw_q        <= rw_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
        end
    end

    assign sda_io    = sda_low_q ? 1'b0 : 1'bz;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_req    = tx_req_q;
    assign addressed = addressed_q;
    assign rw        = rw_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C master plus a transaction-level
// model (expected byte queues and event counts) checked by a monitor.
module tb_i2c_target;

    localparam logic [6:0] ADDR = 7'h50;
    localparam int         Q    = 8;   // quarter SCL period in clk cycles

    logic       clk     = 1'b0;
    logic       reset_i = 1'b1;
    logic       scl     = 1'b1;
    logic       m_low   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda_line;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, addressed, rw, start_det, stop_det;

    assign sda_line = m_low ? 1'b0 : 1'bz;
    pullup (sda_line);

    i2c_target #(.ADDR(ADDR), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .reset_i(reset_i), .scl_i(scl), .sda_io(sda_line),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_req(tx_req), .addressed(addressed), .rw(rw),
        .start_det(start_det), .stop_det(stop_det)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int start_cnt = 0, stop_cnt = 0, txreq_cnt = 0;
    int exp_start = 0, exp_stop = 0, exp_txreq = 0;
    logic [7:0] exp_rx[$], txq[$], tx_preset[$], wr_preset[$], rd_got[$];
    logic [7:0] last_rx = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: checks received bytes every cycle, counts pulses, serves tx_req.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_i) begin
                if (rx_valid) begin
                    if (exp_rx.size() == 0) begin
                        chk("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
                    end else begin
                        last_rx = exp_rx.pop_front();
                        chk("rx_data", rx_data, last_rx);
                    end
                end else begin
                    chk("rx_hold", rx_data, last_rx);
                end
                if (tx_req) begin
                    txreq_cnt++;
                    if (tx_preset.size() != 0) tx_data = tx_preset.pop_front();
                    else tx_data = 8'($urandom);
                    txq.push_back(tx_data);
                end
                if (start_det) start_cnt++;
                if (stop_det) stop_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clock_bit(input logic b, output logic s1, output logic s2);
        m_low = ~b;
        cyc(Q);
        scl = 1'b1;
        cyc(Q);
        s1 = sda_line;
        cyc(Q);
        s2 = sda_line;
        scl = 1'b0;
        cyc(Q);
    endtask

    task automatic do_start();
        m_low = 1'b0;
        cyc(Q);
        scl = 1'b1;
        cyc(Q);
        m_low = 1'b1;
        cyc(Q);
        scl = 1'b0;
        cyc(Q);
        exp_start++;
    endtask

    task automatic do_stop();
        m_low = 1'b1;
        cyc(Q);
        scl = 1'b1;
        cyc(Q);
        m_low = 1'b0;
        cyc(2 * Q);
        exp_stop++;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input logic store);
        logic s1, s2;
        if (store) exp_rx.push_back(d);
        for (int i = 7; i >= 0; i--) begin
            clock_bit(d[i], s1, s2);
            chk("wr_bit", {s1, s2}, {d[i], d[i]});
        end
        clock_bit(1'b1, s1, s2);
        chk("ack", {s1, s2}, exp_ack ? 2'b00 : 2'b11);
    endtask

    task automatic read_byte(input logic m_ack, input logic exp_drive, output logic [7:0] got);
        logic s1, s2;
        logic [7:0] exp, g1, g2;
        exp = 8'hFF;
        if (exp_drive) begin
            chk("tx_avail", txq.size(), 1);
            if (txq.size() != 0) exp = txq.pop_front();
        end
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s1, s2);
            g1[i] = s1;
            g2[i] = s2;
        end
        chk("rd_byte", g1, exp);
        chk("rd_stable", g2, exp);
        clock_bit(~m_ack, s1, s2);
        got = g1;
    endtask

    task automatic txn(input logic [6:0] a, input logic r, input int n, input logic stop_after);
        logic       match;
        logic [7:0] d, got;
        match = (a == ADDR);
        do_start();
        write_byte({a, r}, match, 1'b0);
        chk("addressed", addressed, match);
        if (match) chk("rw", rw, r);
        for (int k = 0; k < n; k++) begin
            if (!r) begin
                d = (wr_preset.size() != 0) ? wr_preset.pop_front() : 8'($urandom);
                write_byte(d, match, match);
                chk("addr_wr", addressed, match);
            end else begin
                read_byte(k < n - 1, match, got);
                rd_got.push_back(got);
            end
        end
        if (r) begin
            if (match) exp_txreq += n;
            chk("addr_nack", addressed, 1'b0);
        end
        if (stop_after) begin
            do_stop();
            chk("addr_stop", addressed, 1'b0);
            chk("sda_rel", sda_line, 1'b1);
        end
        chk("start_cnt", start_cnt, exp_start);
        chk("stop_cnt", stop_cnt, exp_stop);
        chk("txreq_cnt", txreq_cnt, exp_txreq);
        chk("rx_pending", exp_rx.size(), 0);
        chk("tx_left", txq.size(), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rx_data"}, rx_data, 8'h00);
        chk({tag, "_flags"}, {rx_valid, tx_req, addressed, rw, start_det, stop_det}, 6'b0);
        chk({tag, "_sda"}, sda_line, 1'b1);
    endtask

    initial begin
        logic       s1, s2;
        logic [7:0] ab;

        cyc(4);
        chk_outputs_zero("reset");
        reset_i = 1'b0;
        cyc(4);

        // Write 0x3C, 0xC3 to our address.
        wr_preset.push_back(8'h3C);
        wr_preset.push_back(8'hC3);
        txn(ADDR, 1'b0, 2, 1'b1);
        chk("t1_rx_last", rx_data, 8'hC3);

        // Wrong address: no ACK, no data.
        txn(7'h51, 1'b0, 2, 1'b1);
        chk("t2_rx_held", rx_data, 8'hC3);

        // Read two bytes, ACK then NACK.
        tx_preset.push_back(8'h96);
        tx_preset.push_back(8'h5A);
        rd_got.delete();
        txn(ADDR, 1'b1, 2, 1'b1);
        chk("t3_rd0", rd_got[0], 8'h96);
        chk("t3_rd1", rd_got[1], 8'h5A);

        // Write then repeated START into a read.
        wr_preset.push_back(8'h11);
        txn(ADDR, 1'b0, 1, 1'b0);
        chk("t4_rw_wr", rw, 1'b0);
        txn(ADDR, 1'b1, 1, 1'b1);
        chk("t4_rw_rd", rw, 1'b1);
        chk("t4_rx", rx_data, 8'h11);

        // STOP after four data bits of a write.
        do_start();
        write_byte({ADDR, 1'b0}, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) clock_bit(1'($urandom), s1, s2);
        do_stop();
        chk("t5_addr", addressed, 1'b0);
        chk("t5_sda", sda_line, 1'b1);
        chk("t5_rx", rx_data, 8'h11);
        txn(ADDR, 1'b0, 1, 1'b1);

        // Reset while the address ACK is being driven.
        do_start();
        ab = {ADDR, 1'b0};
        for (int i = 7; i >= 0; i--) clock_bit(ab[i], s1, s2);
        m_low = 1'b0;
        cyc(Q / 2);
        chk("t6_ack_drv", sda_line, 1'b0);
        reset_i = 1'b1;
        cyc(1);
        chk_outputs_zero("t6");
        last_rx = 8'h00;
        txq.delete();
        cyc(2);
        reset_i = 1'b0;
        cyc(2);
        do_stop();
        txn(ADDR, 1'b0, 2, 1'b1);

        // Random transactions.
        for (int t = 0; t < 25; t++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : ADDR;
            txn(a, 1'($urandom), $urandom_range(1, 3), 1'b1);
        end

        cyc(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
